// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for a 6-symbol code table.
// It takes one code bit per beat, matches the accumulated bits against the loaded
// table and returns symbol indices 1..6 over a valid/ready interface.
//
// state | meaning
// IDLE  | no table loaded; incoming bits are ignored
// RUN   | table loaded; accepting bits and matching codes
// ERR   | CODE_W bits arrived with no match; held until tbl_load
module huffman_decoder #(
   parameter int CODE_W = 8,
   parameter int SYM_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tbl_load,
   input  logic [CODE_W-1:0] HC1,
   input  logic [CODE_W-1:0] HC2,
   input  logic [CODE_W-1:0] HC3,
   input  logic [CODE_W-1:0] HC4,
   input  logic [CODE_W-1:0] HC5,
   input  logic [CODE_W-1:0] HC6,
   input  logic [CODE_W-1:0] M1,
   input  logic [CODE_W-1:0] M2,
   input  logic [CODE_W-1:0] M3,
   input  logic [CODE_W-1:0] M4,
   input  logic [CODE_W-1:0] M5,
   input  logic [CODE_W-1:0] M6,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic              bit_ready,
   output logic              sym_valid,
   output logic [SYM_W-1:0]  sym_out,
   input  logic              sym_ready,
   output logic              code_err,
   output logic [CNT_W-1:0]  sym_cnt
);

   localparam int LEN_W = $clog2(CODE_W + 1);

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   state_t            state;
   logic [CODE_W-1:0] acc;
   logic [LEN_W-1:0]  len;

   logic [CODE_W-1:0] hc_q [6];
   logic [CODE_W-1:0] m_q  [6];
   logic [LEN_W-1:0]  l_q  [6];

   logic [CODE_W-1:0] hc_in [6];
   logic [CODE_W-1:0] m_in  [6];

   logic [CODE_W-1:0] acc_n;
   logic [LEN_W-1:0]  len_n;
   logic              hit;
   logic [SYM_W-1:0]  hit_sym;
   logic              accept;
   logic              handoff;

   assign hc_in[0] = HC1;
   assign hc_in[1] = HC2;
   assign hc_in[2] = HC3;
   assign hc_in[3] = HC4;
   assign hc_in[4] = HC5;
   assign hc_in[5] = HC6;
   assign m_in[0]  = M1;
   assign m_in[1]  = M2;
   assign m_in[2]  = M3;
   assign m_in[3]  = M4;
   assign m_in[4]  = M5;
   assign m_in[5]  = M6;

   // Code lengths are taken from the masks once at load so the match path has no adder tree.
   function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] v);
      logic [LEN_W-1:0] c;
      c = '0;
      for (int k = 0; k < CODE_W; k++) begin
         c = c + LEN_W'(v[k]);
      end
      return c;
   endfunction

   // A pending symbol blocks new bits until the consumer takes it; the load cycle never accepts.
   assign bit_ready = !reset && !tbl_load && (state == RUN) && (!sym_valid || sym_ready);
   assign accept    = bit_valid && bit_ready;
   assign handoff   = sym_valid && sym_ready;
   assign acc_n     = {acc[CODE_W-2:0], bit_in};
   assign len_n     = len + LEN_W'(1);

   // Compare the would-be accumulator against every enabled code; scanning downward lets the lowest index win.
   always_comb begin
      hit     = 1'b0;
      hit_sym = '0;
      for (int i = 5; i >= 0; i--) begin
         if ((m_q[i] != '0) && (len_n == l_q[i]) && ((acc_n & m_q[i]) == (hc_q[i] & m_q[i]))) begin
            hit     = 1'b1;
            hit_sym = SYM_W'(i + 1);
         end
      end
   end

   // Table registers, captured on tbl_load.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 6; i++) begin
            hc_q[i] <= '0;
            m_q[i]  <= '0;
            l_q[i]  <= '0;
         end
      end else if (tbl_load) begin
         for (int i = 0; i < 6; i++) begin
            hc_q[i] <= hc_in[i];
            m_q[i]  <= m_in[i];
            l_q[i]  <= popcount(m_in[i]);
         end
      end
   end

   // Decode FSM: bit accumulation, symbol output register and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         len       <= '0;
         sym_valid <= 1'b0;
         sym_out   <= '0;
         code_err  <= 1'b0;
      end else if (tbl_load) begin
         state     <= RUN;
         acc       <= '0;
         len       <= '0;
         sym_valid <= 1'b0;
         code_err  <= 1'b0;
      end else begin
         if (handoff) begin
            sym_valid <= 1'b0;
         end
         if (accept) begin
            if (hit) begin
               sym_out   <= hit_sym;
               sym_valid <= 1'b1;
               acc       <= '0;
               len       <= '0;
            end else if (len_n == LEN_W'(CODE_W)) begin
               state    <= ERR;
               code_err <= 1'b1;
            end else begin
               acc <= acc_n;
               len <= len_n;
            end
         end
      end
   end

   // Count symbols actually taken by the consumer; wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         sym_cnt <= '0;
      end else if (handoff) begin
         sym_cnt <= sym_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed scenarios plus random tables and bit streams,
// checked against a bit-string reference decoder.
module tb_huffman_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        tbl_load;
   logic [7:0]  hc [6];
   logic [7:0]  mm [6];
   logic        bit_valid;
   logic        bit_in;
   logic        bit_ready;
   logic        sym_valid;
   logic [2:0]  sym_out;
   logic        sym_ready;
   logic        code_err;
   logic [15:0] sym_cnt;

   int          checks = 0;
   int          errors = 0;

   // Reference model: table as (length, code value) and received bits as an integer.
   int          tl [6];
   int          tc [6];
   int          mv;
   int          mn;
   logic        merr;
   logic [15:0] mcnt;

   huffman_decoder #(.CODE_W(8), .SYM_W(3), .CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .tbl_load  (tbl_load),
      .HC1       (hc[0]),
      .HC2       (hc[1]),
      .HC3       (hc[2]),
      .HC4       (hc[3]),
      .HC5       (hc[4]),
      .HC6       (hc[5]),
      .M1        (mm[0]),
      .M2        (mm[1]),
      .M3        (mm[2]),
      .M4        (mm[3]),
      .M5        (mm[4]),
      .M6        (mm[5]),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .bit_ready (bit_ready),
      .sym_valid (sym_valid),
      .sym_out   (sym_out),
      .sym_ready (sym_ready),
      .code_err  (code_err),
      .sym_cnt   (sym_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_std_table();
      hc[0] = 8'h00; hc[1] = 8'h02; hc[2] = 8'h06; hc[3] = 8'h0E; hc[4] = 8'h1E; hc[5] = 8'h1F;
      mm[0] = 8'h01; mm[1] = 8'h03; mm[2] = 8'h07; mm[3] = 8'h0F; mm[4] = 8'h1F; mm[5] = 8'h1F;
   endtask

   // Called at a negedge: one idle cycle to drain any pending symbol, then a load pulse.
   task automatic load_tbl();
      bit_valid = 1'b0;
      @(negedge clk);
      tbl_load = 1'b1;
      #1 chk("ready_in_load", bit_ready, 1'b0);
      @(negedge clk);
      tbl_load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tl[i] = $countones(mm[i]);
         tc[i] = int'(hc[i] & mm[i]);
      end
      mv   = 0;
      mn   = 0;
      merr = 1'b0;
      chk("load_err_clr", code_err, 1'b0);
      chk("load_valid_clr", sym_valid, 1'b0);
   endtask

   // Called at a negedge: offer one bit, wait for acceptance, then check against the model.
   task automatic step_bit(input logic b);
      bit ok;
      int found;
      ok        = 1'b0;
      bit_valid = 1'b1;
      bit_in    = b;
      for (int w = 0; w < 20 && !ok; w++) begin
         #1 ok = bit_ready;
         @(negedge clk);
      end
      bit_valid = 1'b0;
      if (!ok) begin
         chk("accept_timeout", 1'b0, 1'b1);
         return;
      end
      mv    = mv * 2 + int'(b);
      mn    = mn + 1;
      found = 0;
      for (int i = 0; i < 6; i++) begin
         if (found == 0 && tl[i] != 0 && tl[i] == mn && mv == tc[i]) found = i + 1;
      end
      chk("sym_cnt", sym_cnt, mcnt);
      chk("sym_valid", sym_valid, found != 0);
      if (found != 0) begin
         chk("sym_out", sym_out, found);
         mv   = 0;
         mn   = 0;
         mcnt = mcnt + 16'd1;
      end else if (mn == 8) begin
         merr = 1'b1;
      end
      chk("code_err", code_err, merr);
      if (merr) chk("ready_in_err", bit_ready, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      tbl_load  = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      sym_ready = 1'b1;
      mcnt      = '0;
      mv        = 0;
      mn        = 0;
      merr      = 1'b0;
      for (int i = 0; i < 6; i++) begin
         hc[i] = '0; mm[i] = '0; tl[i] = 0; tc[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_bit_ready", bit_ready, 1'b0);
      chk("rst_sym_valid", sym_valid, 1'b0);
      chk("rst_sym_out", sym_out, 3'd0);
      chk("rst_code_err", code_err, 1'b0);
      chk("rst_sym_cnt", sym_cnt, 16'd0);
      reset = 1'b0;

      // Bits offered with no table loaded are ignored.
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ready", bit_ready, 1'b0);
         chk("idle_valid", sym_valid, 1'b0);
         chk("idle_err", code_err, 1'b0);
      end
      bit_valid = 1'b0;

      // Stream 0,1,0,1,1,0 -> symbols 1,2,3.
      set_std_table();
      load_tbl();
      step_bit(1'b0); step_bit(1'b1); step_bit(1'b0);
      step_bit(1'b1); step_bit(1'b1); step_bit(1'b0);
      @(negedge clk);
      chk("t1_cnt", sym_cnt, 16'd3);

      // 11111 then 11110 -> symbols 6 and 5, each valid for one cycle.
      step_bit(1'b1); step_bit(1'b1); step_bit(1'b1); step_bit(1'b1); step_bit(1'b1);
      step_bit(1'b1); step_bit(1'b1); step_bit(1'b1); step_bit(1'b1); step_bit(1'b0);
      @(negedge clk);
      chk("t2_valid_drop", sym_valid, 1'b0);
      chk("t2_cnt", sym_cnt, 16'd5);

      // Backpressure on stream 0,0.
      step_bit(1'b0);
      sym_ready = 1'b0;
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      #1 chk("bp_ready_low", bit_ready, 1'b0);
      @(negedge clk);
      chk("bp_hold_valid", sym_valid, 1'b1);
      chk("bp_hold_sym", sym_out, 3'd1);
      chk("bp_hold_cnt", sym_cnt, mcnt - 16'd1);
      sym_ready = 1'b1;
      #1 chk("bp_ready_high", bit_ready, 1'b1);
      @(negedge clk);
      bit_valid = 1'b0;
      chk("bp_b2b_valid", sym_valid, 1'b1);
      chk("bp_b2b_sym", sym_out, 3'd1);
      chk("bp_b2b_cnt", sym_cnt, mcnt);
      @(negedge clk);
      mcnt = mcnt + 16'd1;
      chk("bp_final_cnt", sym_cnt, 16'd7);
      chk("bp_final_valid", sym_valid, 1'b0);

      // Symbol 6 disabled: eight ones overflow into the error state.
      mm[5] = 8'h00;
      load_tbl();
      for (int k = 0; k < 8; k++) step_bit(1'b1);
      chk("err_set", code_err, 1'b1);
      chk("err_no_sym", sym_valid, 1'b0);
      set_std_table();
      load_tbl();
      #1 chk("err_leave_ready", bit_ready, 1'b1);

      // A reload discards a partial code.
      step_bit(1'b1); step_bit(1'b1);
      load_tbl();
      step_bit(1'b0);
      chk("partial_sym", sym_out, 3'd1);

      // Reset mid-code returns everything to reset values.
      step_bit(1'b1); step_bit(1'b1); step_bit(1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mcnt  = '0;
      chk("mid_rst_valid", sym_valid, 1'b0);
      chk("mid_rst_sym", sym_out, 3'd0);
      chk("mid_rst_cnt", sym_cnt, 16'd0);
      chk("mid_rst_err", code_err, 1'b0);
      bit_valid = 1'b1;
      repeat (3) begin
         #1 chk("mid_rst_ready", bit_ready, 1'b0);
         @(negedge clk);
         chk("mid_rst_no_sym", sym_valid, 1'b0);
      end
      bit_valid = 1'b0;

      // Random tables (possibly non-prefix-free, disabled entries, junk above the mask) and random bits.
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 6; i++) begin
            int l;
            l     = $urandom_range(0, 8);
            mm[i] = 8'((1 << l) - 1);
            hc[i] = 8'($urandom);
         end
         load_tbl();
         for (int k = 0; k < 60 && !merr; k++) begin
            step_bit(1'($urandom_range(0, 1)));
         end
      end
      @(negedge clk);
      chk("final_cnt", sym_cnt, mcnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
